enemy_stage_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 37 +++
 rtl/enemy_stage_ctrl_if.sv | 17 +
 rtl/enemy_stage_ctrl_phase_timer.sv | 46 ++++
 rtl/enemy_stage_ctrl.sv | 119 +++++++++++
 tb/tb_enemy_stage_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Types and constants shared by the enemy stage sequencer and the enemy
// position calculator.
//   PHASE_1..PHASE_4 : formation phase codes
//   stage_state_t    : {phase[1:0], tick[6:0]} stage state word
//   stage_fsm_t      : sequencer states
//   MAX_ENEMY_DEF    : default enemy count / alive-mask width
//   PHASE_LEN_DEF    : default ticks per phase (legal 2..127)
// ----------------------------------------------------------------------------
package game_pkg;

    localparam logic [1:0] PHASE_1 = 2'b00;
    localparam logic [1:0] PHASE_2 = 2'b01;
    localparam logic [1:0] PHASE_3 = 2'b10;
    localparam logic [1:0] PHASE_4 = 2'b11;

    localparam int MAX_ENEMY_DEF = 15;
    localparam int PHASE_LEN_DEF = 71;

    typedef struct packed {
        logic [1:0] phase;
        logic [6:0] tick;
    } stage_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } stage_fsm_t;

    // Phase is a plain modulo-4 counter: PHASE_4 wraps back to PHASE_1.
    function automatic logic [1:0] nextPhase(input logic [1:0] phase);
        return phase + 2'd1;
    endfunction

endpackage

// File: rtl/enemy_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// enemy_stage_ctrl_if
// Collision-hit handshake between the collision detector and the enemy
// stage sequencer.
//   hit_valid : collision report valid
//   hit_index : index of the enemy that was hit
//   hit_ack   : one-cycle pulse, hit accepted and enemy killed
// Modports: master = collision detector, slave = sequencer.
// ----------------------------------------------------------------------------
interface enemy_stage_ctrl_if;
    logic       hit_valid;
    logic [3:0] hit_index;
    logic       hit_ack;

    modport master (output hit_valid, output hit_index, input hit_ack);
    modport slave  (input hit_valid, input hit_index, output hit_ack);
endinterface

// File: rtl/enemy_stage_ctrl_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Tick/phase counter of the enemy formation. Each enabled cycle adds `step`
// to tick; once the sum reaches PHASE_LEN tick restarts at 0 (no remainder)
// and phase advances modulo 4.
//   clk, rst_n  : clock, async active-low reset
//   en          : advance this cycle
//   clr         : synchronous clear to {PHASE_1, 0}, wins over en
//   step        : tick increment (1 or 2)
//   stage_state : registered {phase, tick}
// ----------------------------------------------------------------------------
module phase_timer
    import game_pkg::*;
#(
    parameter int PHASE_LEN = PHASE_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [1:0]   step,
    output stage_state_t stage_state
);

    // 8-bit sum so tick (max 126) plus step (max 2) cannot overflow.
    logic [7:0] tickSum;

    assign tickSum = {1'b0, stage_state.tick} + {6'd0, step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_state <= '0;
        end else if (clr) begin
            stage_state.phase <= PHASE_1;
            stage_state.tick  <= 7'd0;
        end else if (en) begin
            if (tickSum >= 8'(PHASE_LEN)) begin
                stage_state.tick  <= 7'd0;
                stage_state.phase <= nextPhase(stage_state.phase);
            end else begin
                stage_state.tick  <= tickSum[6:0];
            end
        end
    end

endmodule

// File: rtl/enemy_stage_ctrl.sv
// ----------------------------------------------------------------------------
// enemy_stage_ctrl
// Enemy formation sequencer: owns the alive mask and its population count,
// accepts collision hits, and drives the stage state {phase, tick} through
// phase_timer. Optional build macro ENEMY_SPEEDUP_EN: tick step becomes 2
// while 5 or fewer enemies are alive.
//   clk, rst_n  : clock, async active-low reset
//   start       : level-sampled stage start request (IDLE/CLEAR only)
//   frame_tick  : one pulse per video frame, advances formation in RUN
//   hit         : collision handshake (slave modport)
//   enemy_state : alive mask, bit i = enemy i alive
//   stage_state : {phase, tick}
//   alive_count : popcount of enemy_state, kept as a registered counter
//   running     : FSM in RUN
//   stage_clear : FSM in CLEAR
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, waits for start, ignores frames and hits
// ST_RUN   | formation moves on frame_tick, hits kill enemies
// ST_CLEAR | last enemy killed, stage state frozen, waits for start
// ----------------------------------------------------------------------------
module enemy_stage_ctrl
    import game_pkg::*;
#(
    parameter int MAX_ENEMY = MAX_ENEMY_DEF,
    parameter int PHASE_LEN = PHASE_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  frame_tick,
    enemy_stage_ctrl_if.slave     hit,
    output logic [MAX_ENEMY-1:0]  enemy_state,
    output stage_state_t          stage_state,
    output logic [3:0]            alive_count,
    output logic                  running,
    output logic                  stage_clear
);

    localparam logic [MAX_ENEMY-1:0] ONE_HOT0 = {{(MAX_ENEMY-1){1'b0}}, 1'b1};

    stage_fsm_t           state;
    logic [MAX_ENEMY-1:0] maskShifted;
    logic                 hitInRange;
    logic                 hitAccept;
    logic                 stageInit;
    logic                 timerEn;
    logic [1:0]           step;

    // Shifting instead of indexing keeps an out-of-range index harmless.
    assign maskShifted = enemy_state >> hit.hit_index;
    assign hitInRange  = int'(hit.hit_index) < MAX_ENEMY;
    assign hitAccept   = (state == ST_RUN) && hit.hit_valid && hitInRange && maskShifted[0];

    assign stageInit   = (state != ST_RUN) && start;
    assign timerEn     = (state == ST_RUN) && frame_tick;

`ifdef ENEMY_SPEEDUP_EN
    // Uses the registered count, so a hit in the same cycle does not
    // change this cycle's step.
    assign step = (alive_count <= 4'd5) ? 2'd2 : 2'd1;
`else
    assign step = 2'd1;
`endif

    phase_timer #(
        .PHASE_LEN (PHASE_LEN)
    ) u_phase_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (timerEn),
        .clr         (stageInit),
        .step        (step),
        .stage_state (stage_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            enemy_state <= '0;
            alive_count <= 4'd0;
            hit.hit_ack <= 1'b0;
            running     <= 1'b0;
            stage_clear <= 1'b0;
        end else begin
            hit.hit_ack <= 1'b0;
            case (state)
                ST_IDLE, ST_CLEAR: begin
                    if (start) begin
                        state       <= ST_RUN;
                        enemy_state <= '1;
                        alive_count <= 4'(MAX_ENEMY);
                        running     <= 1'b1;
                        stage_clear <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (hitAccept) begin
                        enemy_state <= enemy_state & ~(ONE_HOT0 << hit.hit_index);
                        alive_count <= alive_count - 4'd1;
                        hit.hit_ack <= 1'b1;
                        if (alive_count == 4'd1) begin
                            state       <= ST_CLEAR;
                            running     <= 1'b0;
                            stage_clear <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    running     <= 1'b0;
                    stage_clear <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_stage_ctrl.sv
module tb_enemy_stage_ctrl;
    import game_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         frame_tick;
    logic [14:0]  enemy_state;
    stage_state_t stage_state;
    logic [3:0]   alive_count;
    logic         running;
    logic         stage_clear;

    int nChecks = 0;
    int nFail   = 0;

    enemy_stage_ctrl_if hitIf();

    enemy_stage_ctrl #(
        .MAX_ENEMY (15),
        .PHASE_LEN (71)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_tick  (frame_tick),
        .hit         (hitIf),
        .enemy_state (enemy_state),
        .stage_state (stage_state),
        .alive_count (alive_count),
        .running     (running),
        .stage_clear (stage_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic frames(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_hit(input logic [3:0] idx);
        hitIf.hit_valid = 1'b1;
        hitIf.hit_index = idx;
        @(negedge clk);
        hitIf.hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        frame_tick = 1'b0;
        hitIf.hit_valid = 1'b0;
        hitIf.hit_index = 4'd0;
        repeat (2) @(negedge clk);
        nChecks++; if (enemy_state !== 15'h0) begin nFail++; $display("FAIL reset_mask got %h want 0", enemy_state); end
        nChecks++; if (stage_state !== 9'h0) begin nFail++; $display("FAIL reset_stage got %h want 0", stage_state); end
        nChecks++; if (alive_count !== 4'd0) begin nFail++; $display("FAIL reset_count got %0d want 0", alive_count); end
        nChecks++; if ({hitIf.hit_ack, running, stage_clear} !== 3'b000) begin nFail++; $display("FAIL reset_flags got %b want 000", {hitIf.hit_ack, running, stage_clear}); end
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++; if (running !== 1'b0) begin nFail++; $display("FAIL idle_hold got %b want 0", running); end
    endtask

    task automatic test_start();
        do_start();
        nChecks++; if (running !== 1'b1) begin nFail++; $display("FAIL start_running got %b want 1", running); end
        nChecks++; if (enemy_state !== 15'h7FFF) begin nFail++; $display("FAIL start_mask got %h want 7fff", enemy_state); end
        nChecks++; if (alive_count !== 4'd15) begin nFail++; $display("FAIL start_count got %0d want 15", alive_count); end
        nChecks++; if (stage_state !== 9'h0) begin nFail++; $display("FAIL start_stage got %h want 0", stage_state); end
        nChecks++; if (stage_clear !== 1'b0) begin nFail++; $display("FAIL start_clear got %b want 0", stage_clear); end
    endtask

    task automatic test_phase_advance();
        frames(1);
        nChecks++; if (stage_state !== {2'b00, 7'd1}) begin nFail++; $display("FAIL tick1 got %h want 001", stage_state); end
        frames(69);
        nChecks++; if (stage_state !== {2'b00, 7'd70}) begin nFail++; $display("FAIL tick70 got %h want %h", stage_state, {2'b00, 7'd70}); end
        frames(1);
        nChecks++; if (stage_state !== {2'b01, 7'd0}) begin nFail++; $display("FAIL phase1 got %h want %h", stage_state, {2'b01, 7'd0}); end
        frames(71);
        nChecks++; if (stage_state !== {2'b10, 7'd0}) begin nFail++; $display("FAIL phase2 got %h want %h", stage_state, {2'b10, 7'd0}); end
        frames(142);
        nChecks++; if (stage_state !== {2'b00, 7'd0}) begin nFail++; $display("FAIL phase_wrap got %h want 000", stage_state); end
    endtask

    task automatic test_hit();
        do_hit(4'd3);
        nChecks++; if (hitIf.hit_ack !== 1'b1) begin nFail++; $display("FAIL hit3_ack got %b want 1", hitIf.hit_ack); end
        nChecks++; if (enemy_state !== 15'h7FF7) begin nFail++; $display("FAIL hit3_mask got %h want 7ff7", enemy_state); end
        nChecks++; if (alive_count !== 4'd14) begin nFail++; $display("FAIL hit3_count got %0d want 14", alive_count); end
        @(negedge clk);
        nChecks++; if (hitIf.hit_ack !== 1'b0) begin nFail++; $display("FAIL ack_pulse got %b want 0", hitIf.hit_ack); end
        do_hit(4'd3);
        nChecks++; if (hitIf.hit_ack !== 1'b0 || enemy_state !== 15'h7FF7) begin nFail++; $display("FAIL dead_hit got ack %b mask %h want 0 7ff7", hitIf.hit_ack, enemy_state); end
        do_hit(4'd15);
        nChecks++; if (hitIf.hit_ack !== 1'b0 || enemy_state !== 15'h7FF7 || alive_count !== 4'd14) begin nFail++; $display("FAIL range_hit got ack %b mask %h cnt %0d want 0 7ff7 14", hitIf.hit_ack, enemy_state, alive_count); end
        do_start();
        nChecks++; if (enemy_state !== 15'h7FF7) begin nFail++; $display("FAIL start_in_run got %h want 7ff7", enemy_state); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        for (int k = 0; k < 15; k++) begin
            hitIf.hit_valid = 1'b1;
            hitIf.hit_index = 4'(k);
            frame_tick = (k == 7);
            @(negedge clk);
            if (hitIf.hit_ack === 1'b1) acks++;
            if (k == 13) begin
                nChecks++; if (stage_clear !== 1'b0 || alive_count !== 4'd1) begin nFail++; $display("FAIL early_clear got clr %b cnt %0d want 0 1", stage_clear, alive_count); end
            end
        end
        hitIf.hit_valid = 1'b0;
        frame_tick = 1'b0;
        nChecks++; if (acks != 15) begin nFail++; $display("FAIL kill_acks got %0d want 15", acks); end
        nChecks++; if (stage_state !== {2'b00, 7'd1}) begin nFail++; $display("FAIL kill_tick got %h want 001", stage_state); end
        nChecks++; if (stage_clear !== 1'b1 || running !== 1'b0) begin nFail++; $display("FAIL kill_clear got clr %b run %b want 1 0", stage_clear, running); end
        nChecks++; if (enemy_state !== 15'h0 || alive_count !== 4'd0) begin nFail++; $display("FAIL kill_mask got %h cnt %0d want 0 0", enemy_state, alive_count); end
        frames(3);
        nChecks++; if (stage_state !== {2'b00, 7'd1}) begin nFail++; $display("FAIL clear_freeze got %h want 001", stage_state); end
    endtask

    task automatic test_speedup();
        do_start();
        nChecks++; if (running !== 1'b1 || alive_count !== 4'd15 || stage_state !== 9'h0) begin nFail++; $display("FAIL restart got run %b cnt %0d st %h want 1 15 0", running, alive_count, stage_state); end
        frames(68);
        nChecks++; if (stage_state !== {2'b00, 7'd68}) begin nFail++; $display("FAIL tick68 got %h want %h", stage_state, {2'b00, 7'd68}); end
        for (int k = 0; k < 10; k++) do_hit(4'(k));
        nChecks++; if (alive_count !== 4'd5 || stage_state !== {2'b00, 7'd68}) begin nFail++; $display("FAIL five_alive got cnt %0d st %h want 5 044", alive_count, stage_state); end
        frames(1);
`ifdef ENEMY_SPEEDUP_EN
        nChecks++; if (stage_state !== {2'b00, 7'd70}) begin nFail++; $display("FAIL speed_step got %h want %h", stage_state, {2'b00, 7'd70}); end
        frames(1);
        nChecks++; if (stage_state !== {2'b01, 7'd0}) begin nFail++; $display("FAIL speed_wrap got %h want %h", stage_state, {2'b01, 7'd0}); end
`else
        nChecks++; if (stage_state !== {2'b00, 7'd69}) begin nFail++; $display("FAIL normal_step got %h want %h", stage_state, {2'b00, 7'd69}); end
        frames(1);
        nChecks++; if (stage_state !== {2'b00, 7'd70}) begin nFail++; $display("FAIL normal_step2 got %h want %h", stage_state, {2'b00, 7'd70}); end
`endif
    endtask

    task automatic test_reset_midrun();
        hitIf.hit_valid = 1'b1;
        hitIf.hit_index = 4'd12;
        frame_tick = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (enemy_state !== 15'h0 || stage_state !== 9'h0 || alive_count !== 4'd0) begin nFail++; $display("FAIL async_rst_data got %h %h %0d want 0 0 0", enemy_state, stage_state, alive_count); end
        nChecks++; if ({hitIf.hit_ack, running, stage_clear} !== 3'b000) begin nFail++; $display("FAIL async_rst_flags got %b want 000", {hitIf.hit_ack, running, stage_clear}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (running !== 1'b0 || enemy_state !== 15'h0 || stage_state !== 9'h0 || hitIf.hit_ack !== 1'b0) begin nFail++; $display("FAIL idle_after_rst got run %b mask %h st %h ack %b want 0 0 0 0", running, enemy_state, stage_state, hitIf.hit_ack); end
        hitIf.hit_valid = 1'b0;
        frame_tick = 1'b0;
        do_start();
        nChecks++; if (running !== 1'b1 || enemy_state !== 15'h7FFF) begin nFail++; $display("FAIL start_after_rst got run %b mask %h want 1 7fff", running, enemy_state); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_phase_advance();
        test_hit();
        test_back_to_back();
        test_speedup();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
